rng_capture_ctrl: RTL and testbench

Sequencer that sits between `lfsr_rng` and `RAM`. On a start pulse it:
- drives `request` to the generator;
- writes `RAM_DEPTH` consecutive random words into RAM addresses 0..RAM_DEPTH-1;
- reads the RAM back and counts every unordered pair of equal words.

This replaces bench-side fill/compare loops with synthesizable hardware. It reports a one-cycle `done` pulse and a duplicate-pair count.

---
 rtl/rng_capture_ctrl.sv | 159 +++++++++++++++
 tb/tb_rng_capture_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_capture_ctrl.sv
// Capture sequencer between lfsr_rng and a registered-read RAM: fills RAM_DEPTH
// random words, then reads every unordered pair back and counts equal pairs.
module rng_capture_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rnd,
  output logic                  request,
  output logic                  we_o,
  output logic                  rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           dup_count
);

  localparam int IDX_W = (RAM_DEPTH < 2) ? 1 : $clog2(RAM_DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(RAM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, PRIME, FILL, RD_A, CAP_A, RD_B, CMP, DONE
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      k;
  logic [IDX_W-1:0]      i;
  logic [IDX_W-1:0]      j;
  logic [DATA_WIDTH-1:0] a_reg;

  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [IDX_W-1:0] idx);
    return ADDR_WIDTH'(idx);
  endfunction

  // Count never wraps: pins at all-ones for absurdly large depths.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // The generator word goes straight to RAM so the write lands in the same cycle.
  assign wdata_o = (state == FILL) ? rnd : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      request   <= 1'b0;
      we_o      <= 1'b0;
      rd_o      <= 1'b0;
      addr_o    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dup_count <= '0;
      k         <= '0;
      i         <= '0;
      j         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= PRIME;
            dup_count <= '0;
            request   <= 1'b1;
            busy      <= 1'b1;
            we_o      <= 1'b0;
            rd_o      <= 1'b0;
            addr_o    <= '0;
          end
        end

        PRIME: begin
          state   <= FILL;
          k       <= '0;
          request <= 1'b1;
          we_o    <= 1'b1;
          addr_o  <= '0;
        end

        FILL: begin
          if (k == LAST) begin
            request <= 1'b0;
            we_o    <= 1'b0;
            addr_o  <= '0;
            if (RAM_DEPTH == 1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RD_A;
              i     <= '0;
              rd_o  <= 1'b1;
            end
          end else begin
            k      <= k + IDX_W'(1);
            addr_o <= to_addr(k + IDX_W'(1));
          end
        end

        RD_A: begin
          state <= CAP_A;
          rd_o  <= 1'b0;
        end

        // Word i arrives one cycle after its read strobe.
        CAP_A: begin
          a_reg  <= rdata_i;
          j      <= i + IDX_W'(1);
          state  <= RD_B;
          rd_o   <= 1'b1;
          addr_o <= to_addr(i + IDX_W'(1));
        end

        RD_B: begin
          state <= CMP;
          rd_o  <= 1'b0;
        end

        CMP: begin
          if (rdata_i == a_reg) dup_count <= sat_inc(dup_count);
          if (j < LAST) begin
            j      <= j + IDX_W'(1);
            state  <= RD_B;
            rd_o   <= 1'b1;
            addr_o <= to_addr(j + IDX_W'(1));
          end else if ((i + IDX_W'(1)) < LAST) begin
            i      <= i + IDX_W'(1);
            state  <= RD_A;
            rd_o   <= 1'b1;
            addr_o <= to_addr(i + IDX_W'(1));
          end else begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            addr_o <= '0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          request <= 1'b0;
          we_o    <= 1'b0;
          rd_o    <= 1'b0;
          busy    <= 1'b0;
          addr_o  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_capture_ctrl.sv
// Bench for rng_capture_ctrl: three depths (4, 1, 12) each with a bench RAM and a
// request-driven word source; results are checked against a pair-counting model.
module tb_rng_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic [31:0] rnd_v   [3];
  logic [31:0] wdata_v [3];
  logic [31:0] rdata_v [3];
  logic [31:0] addr_v  [3];
  logic [31:0] dup_v   [3];
  logic        req_v   [3];
  logic        we_v    [3];
  logic        rd_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];

  logic [31:0] ram  [3][16];
  logic [31:0] vals [3][64];
  logic [5:0]  gp   [3];
  int          depth_of [3] = '{4, 1, 12};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rng_capture_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .rnd(rnd_v[0]), .request(req_v[0]),
    .we_o(we_v[0]), .rd_o(rd_v[0]), .addr_o(addr_v[0]), .wdata_o(wdata_v[0]),
    .rdata_i(rdata_v[0]), .busy(busy_v[0]), .done(done_v[0]), .dup_count(dup_v[0]));

  rng_capture_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .rnd(rnd_v[1]), .request(req_v[1]),
    .we_o(we_v[1]), .rd_o(rd_v[1]), .addr_o(addr_v[1]), .wdata_o(wdata_v[1]),
    .rdata_i(rdata_v[1]), .busy(busy_v[1]), .done(done_v[1]), .dup_count(dup_v[1]));

  rng_capture_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(12)) dut12 (
    .clk(clk), .rst(rst), .start(start_v[2]), .rnd(rnd_v[2]), .request(req_v[2]),
    .we_o(we_v[2]), .rd_o(rd_v[2]), .addr_o(addr_v[2]), .wdata_o(wdata_v[2]),
    .rdata_i(rdata_v[2]), .busy(busy_v[2]), .done(done_v[2]), .dup_count(dup_v[2]));

  // Word source: advances one entry per cycle that request is high.
  always_comb begin
    for (int n = 0; n < 3; n++) rnd_v[n] = vals[n][gp[n]];
  end

  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (rst) gp[n] <= '0;
      else if (req_v[n]) gp[n] <= gp[n] + 6'd1;
      if (we_v[n]) ram[n][addr_v[n][3:0]] <= wdata_v[n];
      if (rd_v[n]) rdata_v[n] <= ram[n][addr_v[n][3:0]];
    end
  end

  // The first FILL write takes the entry after the one held while idle.
  function automatic logic [31:0] word(input int sel, input logic [5:0] base, input int k);
    logic [5:0] idx;
    idx = base + 6'(k + 1);
    return vals[sel][idx];
  endfunction

  function automatic int pairs(input int sel, input logic [5:0] base);
    int cnt = 0;
    for (int a = 0; a < depth_of[sel]; a++)
      for (int b = a + 1; b < depth_of[sel]; b++)
        if (word(sel, base, a) == word(sel, base, b)) cnt++;
    return cnt;
  endfunction

  task automatic load(input int sel, input int k, input logic [31:0] v);
    logic [5:0] idx;
    idx = gp[sel] + 6'(k + 1);
    vals[sel][idx] = v;
  endtask

  task automatic run(input int sel, input int pulse_at, output int lat, output int reqc,
                     output int busyc, output int rdc, output int viol);
    bit seen = 0;
    reqc = 0; busyc = 0; rdc = 0; viol = 0; lat = 1;
    @(posedge clk); #1 start_v[sel] = 1'b1;
    @(posedge clk); #1 start_v[sel] = 1'b0;
    for (int c = 0; c < 500; c++) begin
      start_v[sel] = (lat == pulse_at);
      reqc  += int'(req_v[sel]);
      busyc += int'(busy_v[sel]);
      rdc   += int'(rd_v[sel]);
      if (!we_v[sel] && wdata_v[sel] != 0) viol++;
      if (done_v[sel]) begin
        if (addr_v[sel] != 0 || busy_v[sel] || req_v[sel]) viol++;
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_v[sel] = 1'b0;
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      tests++;
      if ({req_v[n], we_v[n], rd_v[n], busy_v[n], done_v[n]} !== 5'b0 ||
          addr_v[n] !== 0 || wdata_v[n] !== 0 || dup_v[n] !== 0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got req=%b we=%b rd=%b busy=%b done=%b addr=%0h wdata=%0h dup=%0d expected all 0",
                 n, req_v[n], we_v[n], rd_v[n], busy_v[n], done_v[n], addr_v[n], wdata_v[n], dup_v[n]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_unique_fill();
    logic [31:0] v [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    int lat, reqc, busyc, rdc, viol, bad;
    for (int k = 0; k < 4; k++) load(0, k, v[k]);
    run(0, 0, lat, reqc, busyc, rdc, viol);
    tests++; if (lat !== 24) begin fails++; $display("FAIL unique_latency: got %0d expected 24", lat); end
    tests++; if (dup_v[0] !== 0) begin fails++; $display("FAIL unique_dup: got %0d expected 0", dup_v[0]); end
    tests++; if (reqc !== 5) begin fails++; $display("FAIL unique_request_cycles: got %0d expected 5", reqc); end
    tests++; if (busyc !== 23) begin fails++; $display("FAIL unique_busy_cycles: got %0d expected 23", busyc); end
    tests++; if (rdc !== 9) begin fails++; $display("FAIL unique_read_cycles: got %0d expected 9", rdc); end
    tests++; if (viol !== 0) begin fails++; $display("FAIL unique_idle_outputs: got %0d violations expected 0", viol); end
    bad = 0;
    for (int k = 0; k < 4; k++) if (ram[0][k] !== v[k]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL unique_ram: got %0d wrong words expected 0", bad); end
  endtask

  task automatic test_all_equal();
    int lat, reqc, busyc, rdc, viol;
    for (int k = 0; k < 4; k++) load(0, k, 32'd5);
    run(0, 0, lat, reqc, busyc, rdc, viol);
    tests++; if (dup_v[0] !== 6) begin fails++; $display("FAIL all_equal_dup: got %0d expected 6", dup_v[0]); end
    tests++; if (lat !== 24) begin fails++; $display("FAIL all_equal_latency: got %0d expected 24", lat); end
  endtask

  task automatic test_single_dup();
    logic [31:0] v [4] = '{32'd7, 32'd8, 32'd7, 32'd9};
    int lat, reqc, busyc, rdc, viol;
    for (int k = 0; k < 4; k++) load(0, k, v[k]);
    run(0, 0, lat, reqc, busyc, rdc, viol);
    tests++; if (dup_v[0] !== 1) begin fails++; $display("FAIL single_dup_count: got %0d expected 1", dup_v[0]); end
    tests++; if (ram[0][2] !== 32'd7) begin fails++; $display("FAIL single_dup_ram2: got %0d expected 7", ram[0][2]); end
  endtask

  task automatic test_reset_mid_fill();
    logic [5:0] base;
    int lat, reqc, busyc, rdc, viol, exp;
    for (int k = 0; k < 4; k++) load(0, k, 32'd3);
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;   // PRIME
    @(posedge clk); #1;                     // first FILL cycle
    @(posedge clk); #1 rst = 1'b1;          // second FILL cycle
    @(posedge clk); #1 rst = 1'b0;
    tests++;
    if ({req_v[0], we_v[0], rd_v[0], busy_v[0], done_v[0]} !== 5'b0 ||
        addr_v[0] !== 0 || wdata_v[0] !== 0 || dup_v[0] !== 0) begin
      fails++;
      $display("FAIL mid_fill_reset: got req=%b we=%b rd=%b busy=%b done=%b addr=%0h wdata=%0h dup=%0d expected all 0",
               req_v[0], we_v[0], rd_v[0], busy_v[0], done_v[0], addr_v[0], wdata_v[0], dup_v[0]);
    end
    base = gp[0];
    for (int k = 0; k < 4; k++) load(0, k, 32'(100 + (k % 2)));
    exp = pairs(0, base);
    run(0, 0, lat, reqc, busyc, rdc, viol);
    tests++; if (lat !== 24) begin fails++; $display("FAIL after_reset_latency: got %0d expected 24", lat); end
    tests++; if (dup_v[0] !== 32'(exp)) begin fails++; $display("FAIL after_reset_dup: got %0d expected %0d", dup_v[0], exp); end
  endtask

  task automatic test_start_ignored();
    logic [5:0] base;
    int lat, reqc, busyc, rdc, viol, exp;
    base = gp[0];
    for (int k = 0; k < 4; k++) load(0, k, $urandom_range(0, 2));
    exp = pairs(0, base);
    run(0, 8, lat, reqc, busyc, rdc, viol);
    tests++; if (lat !== 24) begin fails++; $display("FAIL ignored_start_latency: got %0d expected 24", lat); end
    tests++; if (dup_v[0] !== 32'(exp)) begin fails++; $display("FAIL ignored_start_dup: got %0d expected %0d", dup_v[0], exp); end
    repeat (4) @(posedge clk);
    #1;
    tests++; if (busy_v[0] !== 1'b0) begin fails++; $display("FAIL ignored_start_idle: got busy=%b expected 0", busy_v[0]); end
  endtask

  task automatic test_depth_one();
    int lat, reqc, busyc, rdc, viol;
    logic [31:0] v;
    v = $urandom;
    load(1, 0, v);
    run(1, 0, lat, reqc, busyc, rdc, viol);
    tests++; if (lat !== 3) begin fails++; $display("FAIL depth1_latency: got %0d expected 3", lat); end
    tests++; if (rdc !== 0) begin fails++; $display("FAIL depth1_reads: got %0d expected 0", rdc); end
    tests++; if (dup_v[1] !== 0) begin fails++; $display("FAIL depth1_dup: got %0d expected 0", dup_v[1]); end
    tests++; if (ram[1][0] !== v) begin fails++; $display("FAIL depth1_ram: got %0h expected %0h", ram[1][0], v); end
    tests++; if (reqc !== 2) begin fails++; $display("FAIL depth1_request_cycles: got %0d expected 2", reqc); end
  endtask

  task automatic test_random_depth12();
    logic [5:0] base;
    int lat, reqc, busyc, rdc, viol, exp, bad;
    for (int it = 0; it < 4; it++) begin
      base = gp[2];
      for (int k = 0; k < 12; k++) load(2, k, (it < 3) ? 32'($urandom_range(0, 7)) : $urandom);
      exp = pairs(2, base);
      run(2, 0, lat, reqc, busyc, rdc, viol);
      tests++; if (lat !== 168) begin fails++; $display("FAIL rand%0d_latency: got %0d expected 168", it, lat); end
      tests++; if (dup_v[2] !== 32'(exp)) begin fails++; $display("FAIL rand%0d_dup: got %0d expected %0d", it, dup_v[2], exp); end
      tests++; if (rdc !== 77) begin fails++; $display("FAIL rand%0d_reads: got %0d expected 77", it, rdc); end
      bad = 0;
      for (int k = 0; k < 12; k++) if (ram[2][k] !== word(2, base, k)) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL rand%0d_ram: got %0d wrong words expected 0", it, bad); end
      repeat (3) @(posedge clk);
      #1;
      tests++; if (dup_v[2] !== 32'(exp)) begin fails++; $display("FAIL rand%0d_dup_held: got %0d expected %0d", it, dup_v[2], exp); end
    end
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      start_v[n] = 1'b0;
      for (int e = 0; e < 64; e++) vals[n][e] = $urandom;
    end
    test_reset();
    test_unique_fill();
    test_all_equal();
    test_single_dup();
    test_reset_mid_fill();
    test_start_ignored();
    test_depth_one();
    test_random_depth12();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
